// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner: channel FSM states
// and the board's button channel indices.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btnState_e;

    localparam int unsigned BTN_RESET = 0;
    localparam int unsigned BTN_RUN   = 1;
    localparam int unsigned BTN_WATER = 2;
    localparam int unsigned BTN_OPEN  = 3;
    localparam int unsigned BTN_CLICK = 4;
    localparam int unsigned BTN_COUNT = 5;

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: input synchronizer, debounce FSM with press/release
// acceptance, and a saturating long-press counter.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 20000,
    parameter int unsigned LONG_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rawBtn,
    input  logic lockMask,
    output logic btnLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic longPulse
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_CYCLES - 2);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   s;

    btnState_e          state, stateNext;
    logic [DEB_W-1:0]   debCnt, debCntNext;
    logic [LONG_W-1:0]  longCnt, longCntNext;

    logic pressSet, releaseSet, longSet, levelSet;
    logic pressQ, releaseQ, longQ, levelQ;

    // Metastability synchronizer; only the last stage feeds logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], rawBtn};
        end
    end

    assign s = syncQ[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            debCnt  <= '0;
            longCnt <= '0;
        end else begin
            state   <= stateNext;
            debCnt  <= debCntNext;
            longCnt <= longCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        debCntNext  = debCnt;
        longCntNext = longCnt;
        unique case (state)
            IDLE: begin
                if (s) begin
                    stateNext   = PRESS_WAIT;
                    debCntNext  = '0;
                    longCntNext = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    stateNext = IDLE;
                end else if (debCnt == DEB_LAST) begin
                    stateNext = HELD;
                end else begin
                    debCntNext = debCnt + DEB_W'(1);
                end
            end
            HELD: begin
                if (longCnt != LONG_LAST) begin
                    longCntNext = longCnt + LONG_W'(1);
                end
                if (!s) begin
                    stateNext  = RELEASE_WAIT;
                    debCntNext = '0;
                end
            end
            RELEASE_WAIT: begin
                // Bounce back high resumes the hold with the long count intact.
                if (s) begin
                    stateNext = HELD;
                end else if (debCnt == DEB_LAST) begin
                    stateNext = IDLE;
                end else begin
                    debCntNext = debCnt + DEB_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        pressSet   = 1'b0;
        releaseSet = 1'b0;
        longSet    = 1'b0;
        levelSet   = (stateNext == HELD) || (stateNext == RELEASE_WAIT);
        if (state == PRESS_WAIT && s && debCnt == DEB_LAST) begin
            pressSet = 1'b1;
        end
        if (state == RELEASE_WAIT && !s && debCnt == DEB_LAST) begin
            releaseSet = 1'b1;
        end
        if (state == HELD && longCnt == LONG_FIRE) begin
            longSet = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressQ   <= 1'b0;
            releaseQ <= 1'b0;
            longQ    <= 1'b0;
            levelQ   <= 1'b0;
        end else begin
            pressQ   <= pressSet;
            releaseQ <= releaseSet;
            longQ    <= longSet;
            levelQ   <= levelSet;
        end
    end

    // Lock gates the registered pulses directly so a mask change applies in the same cycle.
    assign btnLevel     = levelQ;
    assign releasePulse = releaseQ;
    assign pressPulse   = pressQ & ~lockMask;
    assign longPulse    = longQ & ~lockMask;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN asynchronous push buttons into debounced levels and
// press/release/long-press pulses, one independent channel per button.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN       = BTN_COUNT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 20000,
    parameter int unsigned LONG_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] raw_btn,
    input  logic [N_BTN-1:0] lock_mask,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic             any_press
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : gChannel
        btn_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) uChannel (
            .clk          (clk),
            .rst_n        (rst_n),
            .rawBtn       (raw_btn[gi]),
            .lockMask     (lock_mask[gi]),
            .btnLevel     (btn_level[gi]),
            .pressPulse   (press_pulse[gi]),
            .releasePulse (release_pulse[gi]),
            .longPulse    (long_pulse[gi])
        );
    end

    assign any_press = |press_pulse;

endmodule
